// File: rtl/count_arbiter_pkg.sv
// Shared types and constants for the counter-sharing arbiter.
// Four requesters take turns owning one external counter.
package count_arbiter_pkg;

  localparam int NREQ  = 4;
  localparam int SEL_W = 2;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    RUN,
    DONE
  } state_t;

  function automatic logic [NREQ-1:0] onehot(input logic [SEL_W-1:0] i);
    logic [NREQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/count_arbiter_rr_pick4.sv
// Combinational round-robin picker over four requests.
// The search starts one past the last owner.
module rr_pick4
  import count_arbiter_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic             valid,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] cand;

  always_comb begin
    valid = |req;
    idx   = '0;
    cand  = '0;
    // Walk farthest-first so the nearest hit overwrites.
    for (int i = NREQ; i >= 1; i--) begin
      cand = ptr + SEL_W'(i);
      if (req[cand]) idx = cand;
    end
  end

endmodule

// File: rtl/count_arbiter.sv
// Session arbiter: grants the shared counter, clears it, lets it
// run to the owner's target length, then pulses done.
module count_arbiter
  import count_arbiter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] len,
  input  logic [WIDTH-1:0]      count,
  output logic                  cnt_clr,
  output logic                  cnt_en,
  output logic [SEL_W-1:0]      mux_sel,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       done,
  output logic                  busy
);

  state_t           state;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] win;
  logic [WIDTH-1:0] target;

  logic             pick_valid;
  logic [SEL_W-1:0] pick_idx;
  logic [WIDTH-1:0] pick_len;

  rr_pick4 u_pick (
    .req   (req),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    pick_len = len[int'(pick_idx)*WIDTH +: WIDTH];
  end

  assign cnt_en = (state == RUN) && (count != target);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      ptr     <= SEL_W'(NREQ - 1);
      win     <= '0;
      target  <= '0;
      cnt_clr <= 1'b0;
      mux_sel <= '0;
      grant   <= '0;
      done    <= '0;
      busy    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_valid) begin
            state   <= CLEAR;
            win     <= pick_idx;
            target  <= pick_len;
            cnt_clr <= 1'b1;
            mux_sel <= pick_idx;
            grant   <= onehot(pick_idx);
            busy    <= 1'b1;
          end
        end
        CLEAR: begin
          state   <= RUN;
          cnt_clr <= 1'b0;
        end
        RUN: begin
          if (count == target) begin
            state   <= DONE;
            mux_sel <= '0;
            grant   <= '0;
            done    <= onehot(win);
          end
        end
        DONE: begin
          state <= IDLE;
          ptr   <= win;
          done  <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_count_arbiter.sv
// Random and directed checks of count_arbiter against a
// session-level reference model with an attached counter.
module tb_count_arbiter;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req;
  logic [4*W-1:0] len;
  logic [W-1:0] count;
  logic         cnt_clr;
  logic         cnt_en;
  logic [1:0]   mux_sel;
  logic [3:0]   grant;
  logic [3:0]   done;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;

  count_arbiter #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .len     (len),
    .count   (count),
    .cnt_clr (cnt_clr),
    .cnt_en  (cnt_en),
    .mux_sel (mux_sel),
    .grant   (grant),
    .done    (done),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp,
               $time);
    end
  endtask

  // Shared counter datapath.
  logic [W-1:0] cnt_q = '0;
  assign count = cnt_q;
  always @(posedge clk) begin
    if (cnt_clr) cnt_q <= '0;
    else if (cnt_en) cnt_q <= cnt_q + 1'b1;
  end

  // Reference model: a session is k = 0 (clear), k = 1..tgt+1
  // (run), k = tgt+2 (done pulse).
  bit m_sess = 0;
  int m_k    = 0;
  int m_tgt  = 0;
  int m_win  = 0;
  int m_ptr  = 3;
  bit started = 0;

  function automatic int pick(input logic [3:0] r, input int p);
    for (int o = 1; o <= 4; o++)
      if (r[(p + o) % 4]) return (p + o) % 4;
    return -1;
  endfunction

  always @(posedge clk) begin
    started = 1;
    if (!reset) begin
      m_sess = 0;
      m_ptr  = 3;
    end else if (!m_sess) begin
      if (req != 0) begin
        m_win  = pick(req, m_ptr);
        m_tgt  = int'(len[m_win*W +: W]);
        m_sess = 1;
        m_k    = 0;
      end
    end else if (m_k == m_tgt + 2) begin
      m_sess = 0;
      m_ptr  = m_win;
    end else begin
      m_k++;
    end
  end

  int dq[$];

  always @(negedge clk) begin
    if (started) begin
      logic [3:0] eg, ed;
      logic [1:0] es;
      bit run;
      run = m_sess && m_k >= 1 && m_k <= m_tgt + 1;
      eg = '0;
      ed = '0;
      es = '0;
      if (m_sess && m_k <= m_tgt + 1) begin
        eg[m_win] = 1'b1;
        es = 2'(m_win);
      end
      if (m_sess && m_k == m_tgt + 2) ed[m_win] = 1'b1;
      check("grant", 32'(grant), 32'(eg));
      check("mux_sel", 32'(mux_sel), 32'(es));
      check("done", 32'(done), 32'(ed));
      check("busy", 32'(busy), 32'(m_sess));
      check("cnt_clr", 32'(cnt_clr), 32'(m_sess && m_k == 0));
      check("cnt_en", 32'(cnt_en), 32'(run && (m_k - 1) < m_tgt));
      check("grant_1hot", 32'($onehot0(grant)), 32'd1);
      check("done_1hot", 32'($onehot0(done)), 32'd1);
      check("clr_en_excl", 32'(cnt_clr && cnt_en), 32'd0);
      if (m_sess && m_k == m_tgt + 2)
        check("count_at_done", 32'(count), 32'(m_tgt));
      if (done != 0)
        for (int i = 0; i < 4; i++) if (done[i]) dq.push_back(i);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (m_sess && n < 600) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("idle_timeout", 32'(m_sess), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    req = '0;
    cycles(2);
    reset = 1'b1;
  endtask

  initial begin
    int n;
    reset = 1'b0;
    req   = '0;
    len   = '0;
    cycles(2);

    // Single session, len0=3: done lands six cycles after release.
    reset = 1'b1;
    req   = 4'b0001;
    len[0*W +: W] = 8'd3;
    n = 0;
    @(negedge clk);
    while (done == 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("lat_done", 32'(n), 32'd6);
    @(posedge clk);
    #1 req = '0;
    wait_idle();

    // All requesting, len=1: strict 0,1,2,3,0 rotation.
    do_reset();
    dq.delete();
    req = 4'b1111;
    for (int i = 0; i < 4; i++) len[i*W +: W] = 8'd1;
    cycles(26);
    req = '0;
    wait_idle();
    check("rr_count", 32'(dq.size() >= 5), 32'd1);
    for (int i = 0; i < 5 && i < dq.size(); i++)
      check("rr_order", 32'(dq[i]), 32'(i % 4));

    // Zero-length target.
    do_reset();
    req = 4'b0100;
    len[2*W +: W] = 8'd0;
    cycles(1);
    req = '0;
    wait_idle();

    // Request dropped and len changed mid-run.
    do_reset();
    dq.delete();
    req = 4'b0010;
    len[1*W +: W] = 8'd5;
    cycles(4);
    req = '0;
    len[1*W +: W] = 8'd9;
    wait_idle();
    check("drop_done", 32'(dq.size() == 1 && dq[0] == 1), 32'd1);

    // Full-scale target, no wrap.
    req = 4'b1000;
    len[3*W +: W] = 8'hff;
    cycles(1);
    req = '0;
    wait_idle();

    // Reset in the middle of a session.
    dq.delete();
    req = 4'b0001;
    len[0*W +: W] = 8'd5;
    cycles(5);
    reset = 1'b0;
    cycles(1);
    reset = 1'b1;
    req = 4'b1001;
    n = 0;
    while (grant == 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("post_rst_grant", 32'(grant), 32'd1);
    check("abort_no_done", 32'(dq.size()), 32'd0);
    #1 req = '0;
    wait_idle();

    // Random traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      req = 4'($urandom);
      for (int i = 0; i < 4; i++)
        len[i*W +: W] = ($urandom_range(0, 199) == 0) ?
                        8'hff : 8'($urandom_range(0, 6));
      reset = ($urandom_range(0, 299) != 0);
    end
    reset = 1'b1;
    req   = '0;
    wait_idle();
    cycles(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/count_arbiter.md
COUNT_ARBITER -- requirements
Module: count_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the width of the shared counter value and the length fields.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-low reset (0 = reset).
REQ-004 SHALL have port req, input, 4 bits: per-requester session request, level-sensitive.
REQ-005 SHALL have port len, input, 4*WIDTH bits: requester i's target count is len[i*WIDTH +: WIDTH].
REQ-006 SHALL have port count, input, WIDTH bits: current value of the shared counter datapath.
REQ-007 SHALL have port cnt_clr, output, 1 bit: synchronous clear strobe to the counter.
REQ-008 SHALL have port cnt_en, output, 1 bit: increment enable to the counter.
REQ-009 SHALL have port mux_sel, output, 2 bits: selects the owning requester's input mux leg.
REQ-010 SHALL have port grant, output, 4 bits: one-hot ownership indication.
REQ-011 SHALL have port done, output, 4 bits: one-cycle completion pulse to the owner.
REQ-012 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-013 SHALL implement four states: IDLE, CLEAR, RUN, DONE.
REQ-014 In IDLE with req != 0, SHALL pick a winner by round-robin, searching from (ptr+1) mod 4, latch the winner index and its len as target, and go to CLEAR on the next edge.
REQ-015 In IDLE with req == 0, SHALL remain in IDLE with all outputs at their reset values.
REQ-016 In CLEAR, SHALL assert cnt_clr=1 and cnt_en=0 for exactly one cycle, then go to RUN.
REQ-017 In RUN, SHALL drive cnt_en = (count != target) combinationally.
REQ-018 In RUN, SHALL go to DONE on the edge where count == target.
REQ-019 In DONE, SHALL pulse done[winner]=1 for one cycle, load ptr=winner, and return to IDLE.
REQ-020 SHALL hold grant[winner]=1 and mux_sel=winner stable from CLEAR through RUN; both SHALL read 0 in IDLE and DONE.
REQ-021 SHALL sample req only in IDLE; deassertion of req or changes to len during a session SHALL be ignored and the session SHALL complete.
REQ-022 With target == 0, SHALL run CLEAR, then one RUN cycle with cnt_en=0, then DONE.
REQ-023 With target == 2^WIDTH-1, SHALL run the full count with no wrap, since the exit occurs before any further increment.
REQ-024 Latency SHALL be fixed: req seen in IDLE, cnt_clr in cycle +1, done pulse in cycle +target+3.
REQ-025 A requester holding req through its own DONE SHALL have lowest priority at the next IDLE arbitration.
REQ-026 SHALL never assert cnt_clr and cnt_en in the same cycle.
REQ-027 At most one bit of grant and at most one bit of done SHALL be set in any cycle.

Reset
REQ-028 When reset=0 at a clock edge, SHALL enter IDLE with ptr=3, so requester 0 has first priority.
REQ-029 During and after reset, outputs SHALL read cnt_clr=0, cnt_en=0, mux_sel=0, grant=0, done=0, busy=0.
REQ-030 A reset asserted mid-session SHALL abort the session with no done pulse and no cnt_clr.

Structure
REQ-031 Package count_arbiter_pkg SHALL hold the state enumeration, NREQ=4, and SEL_W=2.
REQ-032 One sub-module, rr_pick4, SHALL implement the combinational round-robin picker: inputs req[3:0] and ptr[1:0]; outputs valid and idx[1:0].
REQ-033 Target, winner index and ptr SHALL be registers; cnt_en SHALL be the only combinational-from-input output.

Verification
REQ-034 Reset release, req=4'b0001, len0=3, counter model attached -> cnt_clr at cycle 1, cnt_en high for 3 cycles, done=4'b0001 at cycle 6, grant=4'b0001 and mux_sel=0 through RUN.
REQ-035 req=4'b1111 held, all len=1 -> grant order 0,1,2,3,0, each session 4 cycles, done bits in matching order.
REQ-036 Requester 2 only, len2=0 -> CLEAR, one RUN cycle with cnt_en=0, done=4'b0100; cnt_en never asserted.
REQ-037 req1 dropped and len1 changed mid-RUN (len1=5) -> session still ends at count=5 and done=4'b0010.
REQ-038 reset=0 for one cycle during RUN -> next cycle IDLE with all outputs 0, no done pulse; next grant goes to requester 0 when its req is set.
REQ-039 Assertion checks on every cycle: grant one-hot-or-zero, never cnt_clr&&cnt_en, busy == (state != IDLE).
